// File: rtl/word_collector.sv
// word_collector: collects single-cycle word strobes from NCH deserializer
// channels into 1-deep holding registers, round-robin arbitrates them into a
// shared FWFT FIFO and presents a ready/valid stream tagged with the channel.
// Optional feature macro: WC_TSTAMP_EN adds a free-running 16-bit stamp that
// travels with each accepted word and appears on out_tstamp.

// Per-channel holding register, pending flag and sticky overflow flag.
module wc_lane #(
   parameter int PW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          strobe,
   input  logic          gnt,
   input  logic          ovf_clr,
   input  logic [PW-1:0] din,
   output logic [PW-1:0] hold,
   output logic          pending,
   output logic          ovf
);
   // A word is taken when the slot is free or is being emptied this cycle.
   logic take;
   assign take = strobe & (~pending | gnt);

   // Holding register and pending flag; grant without recapture frees the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold    <= '0;
         pending <= 1'b0;
      end else if (take) begin
         hold    <= din;
         pending <= 1'b1;
      end else if (gnt) begin
         pending <= 1'b0;
      end
   end

   // Sticky overflow: a dropped word wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      ovf <= 1'b0;
      else if (strobe & ~take)         ovf <= 1'b1;
      else if (ovf_clr)                ovf <= 1'b0;
   end
endmodule

module word_collector #(
   parameter int CHW = 2,
   parameter int AW  = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [(1<<CHW)*16-1:0]  in_data,
   input  logic [(1<<CHW)-1:0]     in_valid,
   output logic [15:0]             out_data,
   output logic [CHW-1:0]          out_chan,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [AW:0]             fifo_count,
   output logic [(1<<CHW)-1:0]     ovf,
`ifdef WC_TSTAMP_EN
   output logic [15:0]             out_tstamp,
`endif
   input  logic                    ovf_clr
);
   localparam int NCH   = 1 << CHW;
   localparam int DEPTH = 1 << AW;
`ifdef WC_TSTAMP_EN
   localparam int PW = 32;   // {stamp, word}
`else
   localparam int PW = 16;   // word only
`endif
   localparam int EW = CHW + PW;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [NCH-1:0][PW-1:0] din, hold;
   logic [NCH-1:0]         pending, gnt_vec;
   logic [CHW-1:0]         rr_last, gnt_idx;
   logic                   gnt_any;

   logic [EW-1:0]          mem [DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [EW-1:0]          head;
   logic                   push, pop;

`ifdef WC_TSTAMP_EN
   logic [15:0] tcnt;

   // Free-running stamp counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tcnt <= '0;
      else        tcnt <= tcnt + 16'd1;
   end
`endif

   for (genvar c = 0; c < NCH; c++) begin : g_lane
`ifdef WC_TSTAMP_EN
      assign din[c] = {tcnt, in_data[16*c +: 16]};
`else
      assign din[c] = in_data[16*c +: 16];
`endif
      wc_lane #(.PW(PW)) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .strobe  (in_valid[c]),
         .gnt     (gnt_vec[c]),
         .ovf_clr (ovf_clr),
         .din     (din[c]),
         .hold    (hold[c]),
         .pending (pending[c]),
         .ovf     (ovf[c])
      );
   end

   // Round-robin: first pending channel after rr_last; only when FIFO has room
   // as of the start of the cycle (a same-cycle pop does not count).
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_vec = '0;
      if (fifo_count < FULL) begin
         for (int i = 1; i <= NCH; i++) begin
            if (!gnt_any && pending[rr_last + CHW'(i)]) begin
               gnt_any                    = 1'b1;
               gnt_idx                    = rr_last + CHW'(i);
               gnt_vec[rr_last + CHW'(i)] = 1'b1;
            end
         end
      end
   end

   // Round-robin pointer moves only on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       rr_last <= CHW'(NCH-1);
      else if (gnt_any) rr_last <= gnt_idx;
   end

   assign push      = gnt_any;
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid & out_ready;

   // FIFO storage; contents need no reset since out_valid gates the head.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {gnt_idx, hold[gnt_idx]};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign head     = mem[rd_ptr];
   assign out_data = out_valid ? head[15:0] : 16'h0;
   assign out_chan = out_valid ? head[EW-1 -: CHW] : '0;
`ifdef WC_TSTAMP_EN
   assign out_tstamp = out_valid ? head[31:16] : 16'h0;
`endif
endmodule
